if_stage: RTL

- Fetch stage of the rv32i pipeline.
- Owns the PC register and drives the synchronous instruction memory (address in cycle N, data in cycle N+1).
- Owns the IF/ID pipeline register that feeds decode and the hazard detection unit (instruction opcode, rs1/rs2).
- Consumes the stall signal from hazard detection and the redirect from branch/jump/exception resolution; a one-entry hold buffer protects the in-flight fetch while stalled.

---
 rtl/if_stage_if.sv | 27 ++
 rtl/if_stage.sv | 107 ++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its environment: hazard/redirect
// control in, instruction-memory port, and the IF/ID register contents out.
interface if_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  stall;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  imem_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [ADDR_WIDTH-1:0] ifid_pc;
  logic [DATA_WIDTH-1:0] ifid_instruction;
  logic                  ifid_valid;
  logic                  ifid_misaligned;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_en, imem_addr, ifid_pc, ifid_instruction, ifid_valid, ifid_misaligned
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, ifid_pc, ifid_instruction, ifid_valid, ifid_misaligned
  );
endinterface

// File: rtl/if_stage.sv
// rv32i fetch stage: PC register, synchronous imem driver, IF/ID register and a
// one-entry hold buffer that keeps the in-flight fetch alive across stalls.
module if_stage #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  if_stage_if.master   bus
);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] f1_pc_q, f1_pc_d;
  logic                  f1_valid_q, f1_valid_d;
  logic                  f1_misal_q, f1_misal_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [DATA_WIDTH-1:0] ifid_inst_q, ifid_inst_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic                  ifid_misal_q, ifid_misal_d;

  // Memory is always read word-aligned; the raw PC travels with the data.
  assign bus.imem_addr = {fetch_pc_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.imem_en   = !rst && (!bus.stall || bus.redirect);

  assign bus.ifid_pc          = ifid_pc_q;
  assign bus.ifid_instruction = ifid_inst_q;
  assign bus.ifid_valid       = ifid_valid_q;
  assign bus.ifid_misaligned  = ifid_misal_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    f1_pc_d      = f1_pc_q;
    f1_valid_d   = f1_valid_q;
    f1_misal_d   = f1_misal_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    ifid_misal_d = ifid_misal_q;

    if (bus.redirect) begin
      fetch_pc_d   = bus.redirect_pc;
      f1_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
      ifid_misal_d = 1'b0;
    end else if (bus.stall) begin
      // Capture only on the first stalled cycle; memory output is not held.
      if (f1_valid_q && !hold_valid_q) begin
        hold_data_d  = bus.imem_rdata;
        hold_valid_d = 1'b1;
      end
    end else begin
      fetch_pc_d   = fetch_pc_q + ADDR_WIDTH'(4);
      f1_pc_d      = fetch_pc_q;
      f1_valid_d   = 1'b1;
      f1_misal_d   = (fetch_pc_q[1:0] != 2'b00);
      hold_valid_d = 1'b0;
      ifid_pc_d    = f1_pc_q;
      ifid_valid_d = f1_valid_q;
      if (f1_valid_q) begin
        ifid_inst_d  = hold_valid_q ? hold_data_q : bus.imem_rdata;
        ifid_misal_d = f1_misal_q;
      end else begin
        ifid_inst_d  = NOP_INST;
        ifid_misal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      f1_pc_q      <= RESET_PC;
      f1_valid_q   <= 1'b0;
      f1_misal_q   <= 1'b0;
      hold_data_q  <= NOP_INST;
      hold_valid_q <= 1'b0;
      ifid_pc_q    <= RESET_PC;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
      ifid_misal_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      f1_pc_q      <= f1_pc_d;
      f1_valid_q   <= f1_valid_d;
      f1_misal_q   <= f1_misal_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_misal_q <= ifid_misal_d;
    end
  end

  // A held word without an in-flight fetch behind it is never legal.
  hold_implies_f1: assert property (@(posedge clk) disable iff (rst)
    !(hold_valid_q && !f1_valid_q));

endmodule
